// File: rtl/ntt_sched_pkg.sv
// rtl/ntt_sched_pkg.sv - shared FSM state, default butterfly latencies and latency lookup for the NTT scheduler
package ntt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int LAT0_DEF = 5;
  localparam int LAT1_DEF = 6;
  localparam int LAT2_DEF = 7;
  localparam int LAT3_DEF = 8;

  function automatic int lat_of(input logic [1:0] i, input int l0, input int l1,
                                input int l2, input int l3);
    case (i)
      2'd0:    return l0;
      2'd1:    return l1;
      2'd2:    return l2;
      default: return l3;
    endcase
  endfunction

endpackage

// File: rtl/ntt_addr_gen.sv
// rtl/ntt_addr_gen.sv - combinational butterfly pair and twiddle address generator for CT/GS orders
module ntt_addr_gen
  import ntt_sched_pkg::*;
#(
  parameter int LOGN = 8,
  parameter int SW   = $clog2(LOGN)
) (
  input  logic [SW-1:0]   s,
  input  logic [LOGN-2:0] c,
  input  logic            ct,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic [LOGN-1:0] tw_addr
);

  localparam logic [SW-1:0]   SMAX = SW'(LOGN - 1);
  localparam logic [LOGN-1:0] ONE  = {{(LOGN-1){1'b0}}, 1'b1};

  logic [SW-1:0]   sh_len;
  logic [SW-1:0]   sh_tw;
  logic [LOGN-1:0] cx;
  logic [LOGN-1:0] len;
  logic [LOGN-1:0] g;
  logic [LOGN-1:0] o;
  logic [LOGN-1:0] base;

  // CT halves the span each stage while GS doubles it; the twiddle base mirrors that.
  always_comb begin
    sh_len    = ct ? (SMAX - s) : s;
    sh_tw     = ct ? s : (SMAX - s);
    cx        = {1'b0, c};
    len       = ONE << sh_len;
    g         = cx >> sh_len;
    o         = cx & (len - ONE);
    base      = ((g << sh_len) << 1) | o;
    rd_addr_a = base;
    rd_addr_b = base + len;
    tw_addr   = (ONE << sh_tw) + g;
  end

endmodule

// File: rtl/ntt_bf_scheduler.sv
// rtl/ntt_bf_scheduler.sv - NTT stage walker driving one butterfly; optional NTT_SCHED_CYCLE_CNT_EN adds cycle_cnt
module ntt_bf_scheduler
  import ntt_sched_pkg::*;
#(
  parameter int N    = 256,
  parameter int LOGN = 8,
  parameter int W    = 32,
  parameter int LAT0 = LAT0_DEF,
  parameter int LAT1 = LAT1_DEF,
  parameter int LAT2 = LAT2_DEF,
  parameter int LAT3 = LAT3_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            ct,
  input  logic [1:0]      i,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic [LOGN-1:0] tw_addr,
  input  logic [W-1:0]    rd_data_a,
  input  logic [W-1:0]    rd_data_b,
  input  logic [W-1:0]    tw_data,
  output logic [W-1:0]    bf_a,
  output logic [W-1:0]    bf_b,
  output logic [W-1:0]    bf_w,
  output logic            bf_ct,
  output logic [1:0]      bf_i,
  input  logic [W-1:0]    bf_r0,
  input  logic [W-1:0]    bf_r1,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b,
  output logic [W-1:0]    wr_data_a,
  output logic [W-1:0]    wr_data_b,
  output logic            busy,
`ifdef NTT_SCHED_CYCLE_CNT_EN
  output logic [31:0]     cycle_cnt,
`endif
  output logic            done
);

  localparam int SW    = $clog2(LOGN);
  localparam int CW    = LOGN - 1;
  localparam int DEPTH = LAT3 + 1;
  localparam int TW    = $clog2(DEPTH);
  localparam logic [CW-1:0] CLAST = {CW{1'b1}};
  localparam logic [SW-1:0] SLAST = SW'(LOGN - 1);

  state_t          state;
  state_t          state_nx;
  logic [SW-1:0]   s;
  logic [CW-1:0]   c;
  logic            ct_q;
  logic [1:0]      i_q;
  logic            accept;
  logic            pending;
  logic [TW-1:0]   tap;
  logic [DEPTH-1:0] vpipe;
  logic [LOGN-1:0] apipe [DEPTH];
  logic [LOGN-1:0] bpipe [DEPTH];
  logic [LOGN-1:0] gen_a;
  logic [LOGN-1:0] gen_b;
  logic [LOGN-1:0] gen_t;

  ntt_addr_gen #(.LOGN(LOGN), .SW(SW)) u_addr_gen (
    .s         (s),
    .c         (c),
    .ct        (ct_q),
    .rd_addr_a (gen_a),
    .rd_addr_b (gen_b),
    .tw_addr   (gen_t)
  );

  assign accept = (state == IDLE) && start;
  assign tap    = TW'(lat_of(i_q, LAT0, LAT1, LAT2, LAT3));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ISSUE;
      ISSUE:   if (c == CLAST) state_nx = DRAIN;
      DRAIN:   if (!pending) state_nx = (s == SLAST) ? DONE : ISSUE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rd_en     = (state == ISSUE);
    busy      = (state != IDLE);
    done      = (state == DONE);
    rd_addr_a = rd_en ? gen_a : '0;
    rd_addr_b = rd_en ? gen_b : '0;
    tw_addr   = rd_en ? gen_t : '0;
    bf_a      = vpipe[0] ? rd_data_a : '0;
    bf_b      = vpipe[0] ? rd_data_b : '0;
    bf_w      = vpipe[0] ? tw_data : '0;
    bf_ct     = ct_q;
    bf_i      = i_q;
    wr_en     = vpipe[tap];
    wr_addr_a = apipe[tap];
    wr_addr_b = bpipe[tap];
    wr_data_a = wr_en ? bf_r0 : '0;
    wr_data_b = wr_en ? bf_r1 : '0;
  end

  // c wraps to zero after the last pair, so a new stage starts clean without an explicit clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s    <= '0;
      c    <= '0;
      ct_q <= 1'b0;
      i_q  <= 2'd0;
    end else if (accept) begin
      s    <= '0;
      c    <= '0;
      ct_q <= ct;
      i_q  <= i;
    end else if (state == ISSUE) begin
      c <= c + 1'b1;
    end else if (state == DRAIN && !pending && s != SLAST) begin
      s <= s + 1'b1;
    end
  end

  // vpipe[k] marks a read issued k+1 cycles ago; the tap at LAT lines the write up with r0/r1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vpipe <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        apipe[k] <= '0;
        bpipe[k] <= '0;
      end
    end else begin
      vpipe    <= {vpipe[DEPTH-2:0], rd_en};
      apipe[0] <= rd_addr_a;
      bpipe[0] <= rd_addr_b;
      for (int k = 1; k < DEPTH; k++) begin
        apipe[k] <= apipe[k-1];
        bpipe[k] <= bpipe[k-1];
      end
    end
  end

  // Entries below the tap still owe a write; the one at the tap is being written this cycle.
  always_comb begin
    pending = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((TW'(k) < tap) && vpipe[k]) pending = 1'b1;
    end
  end

`ifdef NTT_SCHED_CYCLE_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     cycle_cnt <= '0;
    else if (accept) cycle_cnt <= '0;
    else if (busy)  cycle_cnt <= cycle_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ntt_bf_scheduler.sv
// tb/tb_ntt_bf_scheduler.sv - scoreboard bench for ntt_bf_scheduler at N=8 (optional NTT_SCHED_CYCLE_CNT_EN)
module tb_ntt_bf_scheduler;

  localparam int N = 8;
  localparam int LOGN = 3;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic ct = 1'b0;
  logic [1:0] i = 2'd0;
  logic rd_en, wr_en, busy, done, bf_ct;
  logic [1:0] bf_i;
  logic [LOGN-1:0] rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b;
  logic [W-1:0] rd_data_a, rd_data_b, tw_data, bf_a, bf_b, bf_w, bf_r0, bf_r1, wr_data_a, wr_data_b;
`ifdef NTT_SCHED_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;
`endif

  always #5 clk = ~clk;

  ntt_bf_scheduler #(.N(N), .LOGN(LOGN), .W(W), .LAT0(5), .LAT1(6), .LAT2(7), .LAT3(8)) dut (
    .clk(clk), .reset(reset), .start(start), .ct(ct), .i(i),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .tw_data(tw_data),
    .bf_a(bf_a), .bf_b(bf_b), .bf_w(bf_w), .bf_ct(bf_ct), .bf_i(bf_i),
    .bf_r0(bf_r0), .bf_r1(bf_r1),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .wr_data_a(wr_data_a), .wr_data_b(wr_data_b),
    .busy(busy),
`ifdef NTT_SCHED_CYCLE_CNT_EN
    .cycle_cnt(cycle_cnt),
`endif
    .done(done)
  );

  // Coefficient RAM and twiddle ROM with one-cycle read latency.
  logic [W-1:0] mem [N];
  logic load = 1'b0;
  always @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < N; k++) mem[k] <= k;
    end else if (wr_en) begin
      mem[wr_addr_a] <= wr_data_a;
      mem[wr_addr_b] <= wr_data_b;
    end
    if (rd_en) begin
      rd_data_a <= mem[rd_addr_a];
      rd_data_b <= mem[rd_addr_b];
      tw_data   <= {29'd0, tw_addr} * 16;
    end
  end

  // Butterfly stand-in: r0=a+1, r1=b+2 after bf_lat cycles.
  logic [W-1:0] ra [8];
  logic [W-1:0] rb [8];
  int bf_lat = 5;
  always @(posedge clk) begin
    ra[0] <= bf_a + 1;
    rb[0] <= bf_b + 2;
    for (int k = 1; k < 8; k++) begin
      ra[k] <= ra[k-1];
      rb[k] <= rb[k-1];
    end
  end
  assign bf_r0 = ra[bf_lat-1];
  assign bf_r1 = rb[bf_lat-1];

  typedef struct {int a; int b; int t;} rec_t;
  rec_t rd_q[$];
  rec_t wr_q[$];
  int pend[$];
  rec_t e;

  int ct_tab [12][3] = '{'{0,4,1}, '{1,5,1}, '{2,6,1}, '{3,7,1},
                         '{0,2,2}, '{1,3,2}, '{4,6,3}, '{5,7,3},
                         '{0,1,4}, '{2,3,5}, '{4,5,6}, '{6,7,7}};
  int gs_tab [12][3] = '{'{0,1,4}, '{2,3,5}, '{4,5,6}, '{6,7,7},
                         '{0,2,2}, '{1,3,2}, '{4,6,3}, '{5,7,3},
                         '{0,4,1}, '{1,5,1}, '{2,6,1}, '{3,7,1}};
  int mem_ct [8] = '{3, 5, 6, 8, 8, 10, 11, 13};

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0 = 0;
  int first_rd = -1, first_wr = -1, last_wr = -1, done_cyc = -1, n_wr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit in_pend(input int x);
    foreach (pend[k]) if (pend[k] == x) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expected reads/writes as the DUT presents them.
  always @(negedge clk) begin
    if (reset) begin
      if (rd_en) begin
        if (first_rd < 0) first_rd = cyc - c0;
        chk("raw_hazard_a", in_pend(int'(rd_addr_a)), 0);
        chk("raw_hazard_b", in_pend(int'(rd_addr_b)), 0);
        if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          e = rd_q.pop_front();
          chk("rd_addr_a", rd_addr_a, e.a);
          chk("rd_addr_b", rd_addr_b, e.b);
          chk("tw_addr", tw_addr, e.t);
        end
        pend.push_back(int'(rd_addr_a));
        pend.push_back(int'(rd_addr_b));
      end
      if (wr_en) begin
        n_wr++;
        if (first_wr < 0) first_wr = cyc - c0;
        last_wr = cyc - c0;
        if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          e = wr_q.pop_front();
          chk("wr_addr_a", wr_addr_a, e.a);
          chk("wr_addr_b", wr_addr_b, e.b);
        end
        if (pend.size() >= 2) begin
          void'(pend.pop_front());
          void'(pend.pop_front());
        end
      end
      if (done) done_cyc = cyc - c0;
    end
  end

  task automatic preload();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic issue(input logic ctv, input logic [1:0] iv, input int lat);
    bf_lat = lat;
    for (int r = 0; r < 12; r++) begin
      if (ctv) begin
        rd_q.push_back('{ct_tab[r][0], ct_tab[r][1], ct_tab[r][2]});
        wr_q.push_back('{ct_tab[r][0], ct_tab[r][1], 0});
      end else begin
        rd_q.push_back('{gs_tab[r][0], gs_tab[r][1], gs_tab[r][2]});
        wr_q.push_back('{gs_tab[r][0], gs_tab[r][1], 0});
      end
    end
    first_rd = -1; first_wr = -1; last_wr = -1; done_cyc = -1; n_wr = 0;
    @(negedge clk);
    start = 1'b1; ct = ctv; i = iv; c0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input logic ctv, input logic [1:0] iv, input int lat, input int exp_done, input bit poke);
    preload();
    issue(ctv, iv, lat);
    if (poke) begin
      repeat (3) @(negedge clk);
      start = 1'b1; ct = ~ctv; i = ~iv;
      @(negedge clk);
      start = 1'b0;
    end
    for (int k = 0; k < 100 && done_cyc < 0; k++) @(negedge clk);
    @(negedge clk);
    chk("done_seen", done_cyc >= 0, 1);
    chk("done_cycle", done_cyc, exp_done);
    chk("first_rd_cycle", first_rd, 1);
    chk("first_wr_cycle", first_wr, 2 + lat);
    chk("last_wr_cycle", last_wr, exp_done - 1);
    chk("write_count", n_wr, 12);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("busy_after_done", busy, 0);
    chk("bf_ct_latched", bf_ct, ctv);
    chk("bf_i_latched", bf_i, iv);
`ifdef NTT_SCHED_CYCLE_CNT_EN
    chk("cycle_cnt", cycle_cnt, exp_done);
`endif
    if (ctv) for (int k = 0; k < N; k++) chk("final_mem", mem[k], mem_ct[k]);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bf_ct", bf_ct, 0);
    chk("rst_bf_i", bf_i, 0);
    chk("rst_rd_addr_a", rd_addr_a, 0);
    chk("rst_rd_addr_b", rd_addr_b, 0);
    chk("rst_tw_addr", tw_addr, 0);
    chk("rst_wr_addr_a", wr_addr_a, 0);
    chk("rst_bf_a", bf_a, 0);
`ifdef NTT_SCHED_CYCLE_CNT_EN
    chk("rst_cycle_cnt", cycle_cnt, 0);
`endif
    @(posedge clk); #2 reset = 1'b1;

    run(1'b1, 2'd0, 5, 31, 1'b1);
    run(1'b0, 2'd3, 8, 40, 1'b0);

    // Abandon a transform in stage 1 drain.
    preload();
    issue(1'b1, 2'd0, 5);
    repeat (15) @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_rd_en", rd_en, 0);
    @(posedge clk); #2 reset = 1'b0;
    #1;
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    rd_q.delete(); wr_q.delete(); pend.delete();
    repeat (3) @(negedge clk);
    @(posedge clk); #2 reset = 1'b1;
    n_wr = 0;
    repeat (25) @(negedge clk);
    chk("wr_after_reset", n_wr, 0);

    run(1'b1, 2'd0, 5, 31, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ntt_bf_scheduler.md
Name: ntt_bf_scheduler

Overview:
- Initiator/driver side of the butterfly unit: walks all NTT stages over an N-point coefficient memory.
- Issues read addresses, presents operand pairs and twiddles to the butterfly, and writes r0/r1 back to the same addresses.
- Write-back is latency-matched to the butterfly's i-selected pipeline depth.
- Supports CT (forward) and GS (inverse) addressing orders; sits between the coefficient RAM / twiddle ROM and one butterfly instance.

Parameters:
- N, 256, transform size (power of two, >= 8).
- LOGN, 8, log2(N).
- W, 32, coefficient width.
- LAT0, 5, butterfly result latency in cycles (from operands applied to r0/r1 valid) when i=0.
- LAT1, 6, same for i=1.
- LAT2, 7, same for i=2.
- LAT3, 8, same for i=3.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- ct  in  1  1=CT forward order, 0=GS inverse order; sampled on start.
- i  in  2  butterfly reduction mode (forwarded to the butterfly); sampled on start.
- rd_en  out  1  coefficient RAM read strobe.
- rd_addr_a, rd_addr_b  out  LOGN  read addresses.
- tw_addr  out  LOGN  twiddle ROM address.
- rd_data_a, rd_data_b, tw_data  in  W  synchronous read data, valid 1 cycle after rd_en.
- bf_a, bf_b, bf_w  out  W  butterfly operands; combinational pass-through of the read data.
- bf_ct  out  1  registered copy of ct.
- bf_i  out  2  registered copy of i.
- bf_r0, bf_r1  in  W  butterfly results.
- wr_en  out  1  write strobe.
- wr_addr_a, wr_addr_b  out  LOGN  write addresses.
- wr_data_a, wr_data_b  out  W  = bf_r0, bf_r1.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse after the final write.

Behaviour:
- Reset (asynchronous, reset=0) forces every output low or zero: state=IDLE, counters cleared, in-flight pipe cleared. Reset mid-transform abandons it; no further wr_en.
- FSM:
  - IDLE: on start go to ISSUE, with stage s=0 and pair counter c=0; latch ct and i; LAT = LAT[i].
  - ISSUE: rd_en=1 every cycle; c increments. At c=N/2-1, go to DRAIN.
  - DRAIN: wait until the in-flight pipe is empty. Then, if s=LOGN-1, go to DONE; otherwise s++, c=0, go to ISSUE.
  - DONE: done=1 for one cycle, then go to IDLE.
- start outside IDLE is ignored.
- Address generation:
  - CT: len = N>>(s+1).
  - GS: len = 1<<s.
  - g = c>>log2(len); o = c & (len-1).
  - rd_addr_a = g*2*len + o; rd_addr_b = rd_addr_a + len.
  - CT: tw_addr = (1<<s) + g.
  - GS: tw_addr = (N>>(s+1)) + g.
- Latency: read issued cycle t → operands at butterfly cycle t+1 → wr_en at cycle t+1+LAT, carrying the addresses issued at t. Realised as a valid + address shift line of depth LAT3+1, with the tap selected by the latched i.
- Stage period is N/2+1+LAT cycles. The first read of stage s+1 is issued the cycle after the last write of stage s, so there is no RAW hazard.
- i and ct changes while busy have no effect.

Optional Feature:
- Macro NTT_SCHED_CYCLE_CNT_EN.
- Defined: adds output cycle_cnt (32 bits). Cleared on start acceptance; increments every cycle while busy; holds its value at done until the next start. Reset value 0.
- Undefined: port and counter are absent.

Decomposition:
- Package ntt_sched_pkg holds:
  - FSM state enum (IDLE, ISSUE, DRAIN, DONE);
  - default LAT constants;
  - function lat_of(i).
- Sub-module ntt_addr_gen: combinational index/twiddle generator. Inputs s, c, ct; outputs rd_addr_a, rd_addr_b, tw_addr.

Test Plan:
- N=8, LAT0=5, ct=1, i=0, start: reads per stage are
  - s0: (0,4)(1,5)(2,6)(3,7), tw=1;
  - s1: (0,2)(1,3), tw=2; (4,6)(5,7), tw=3;
  - s2: (0,1)/4, (2,3)/5, (4,5)/6, (6,7)/7.
- N=8, ct=0: s0 pairs (0,1)(2,3)(4,5)(6,7) with tw=4,5,6,7; s2 pairs (0,4)..(3,7) with tw=1.
- Latency, N=8, i=0: first rd_en at cycle 1, first wr_en at cycle 7, last write at cycle 30, done at cycle 31. With i=3, done at cycle 40. Write addresses equal the issued addresses.
- Butterfly model returning r0=a+1, r1=b+2 into a RAM preloaded 0..7, CT run: final memory matches the software model; no read of an address with a write pending.
- Assert reset low during stage 1 DRAIN: wr_en, busy, and done go low immediately; no writes after release; a new start runs a clean full transform.
- start pulsed while busy: ignored. With NTT_SCHED_CYCLE_CNT_EN defined, cycle_cnt=31 at done for N=8, i=0.
